// File: rtl/tea_pkg.sv
// ============================================================================
// Module   : tea_pkg
// Brief    : Shared FSM encoding, default key-schedule constant and the
//            decrypt start-sum helper for the TEA engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package tea_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HALF_A = 2'd1,
        HALF_B = 2'd2,
        DONE   = 2'd3
    } tea_state_t;

    localparam logic [31:0] c_DEFAULT_DELTA = 32'h9e3779b9;

    // Wide product; callers keep the low WORD_SIZE bits (WORD_SIZE <= 128).
    function automatic logic [127:0] delta_times_rounds(input logic [127:0] delta,
                                                        input int unsigned  rounds);
        return delta * 128'(rounds);
    endfunction

endpackage

`default_nettype wire

// File: rtl/tea_round_f.sv
// ============================================================================
// Module   : tea_round_f
// Brief    : Combinational TEA half-round mixing function; the XTEA variant is
//            built in when TEA_CORE_XTEA_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tea_round_f
    import tea_pkg::*;
#(
    parameter int WORD_SIZE = 32
) (
    input  logic [WORD_SIZE-1:0] i_x,
    input  logic [WORD_SIZE-1:0] i_ka,
    input  logic [WORD_SIZE-1:0] i_kb,
    input  logic [WORD_SIZE-1:0] i_sum,
`ifdef TEA_CORE_XTEA_EN
    input  logic                 i_xtea,
`endif
    output logic [WORD_SIZE-1:0] o_f
);

    logic [WORD_SIZE-1:0] w_tea;

    assign w_tea = ((i_x << 4) + i_ka) ^ (i_x + i_sum) ^ ((i_x >> 5) + i_kb);

`ifdef TEA_CORE_XTEA_EN
    logic [WORD_SIZE-1:0] w_xtea;

    // In XTEA mode i_ka carries the key word already selected by the sum.
    assign w_xtea = (((i_x << 4) ^ (i_x >> 5)) + i_x) ^ (i_sum + i_ka);
    assign o_f    = i_xtea ? w_xtea : w_tea;
`else
    assign o_f    = w_tea;
`endif

endmodule

`default_nettype wire

// File: rtl/tea_core.sv
// ============================================================================
// Module   : tea_core
// Brief    : One-half-round-per-clock TEA encrypt/decrypt engine with a
//            start/busy/done handshake. Optional XTEA mode: TEA_CORE_XTEA_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tea_core
    import tea_pkg::*;
#(
    parameter int          WORD_SIZE    = 32,
    parameter logic [31:0] DELTA        = c_DEFAULT_DELTA,
    parameter int          ROUND_NUMBER = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 iStart,
    input  logic                 iDecrypt,
`ifdef TEA_CORE_XTEA_EN
    input  logic                 iXtea,
`endif
    input  logic [WORD_SIZE-1:0] iV0,
    input  logic [WORD_SIZE-1:0] iV1,
    input  logic [WORD_SIZE-1:0] iK0,
    input  logic [WORD_SIZE-1:0] iK1,
    input  logic [WORD_SIZE-1:0] iK2,
    input  logic [WORD_SIZE-1:0] iK3,
    output logic [WORD_SIZE-1:0] oC0,
    output logic [WORD_SIZE-1:0] oC1,
    output logic                 oBusy,
    output logic                 oDone
);

    localparam int                   c_CNT_W     = $clog2(ROUND_NUMBER + 1);
    localparam logic [127:0]         c_DELTA_EXT = 128'(DELTA);
    localparam logic [WORD_SIZE-1:0] c_DELTA     = c_DELTA_EXT[WORD_SIZE-1:0];
    localparam logic [127:0]         c_DEC_EXT   =
        delta_times_rounds(128'(c_DELTA), ROUND_NUMBER);
    localparam logic [WORD_SIZE-1:0] c_DEC_SUM   = c_DEC_EXT[WORD_SIZE-1:0];
    localparam logic [c_CNT_W-1:0]   c_LAST      = c_CNT_W'(ROUND_NUMBER - 1);

    tea_state_t           r_state;
    tea_state_t           w_state_next;
    logic [WORD_SIZE-1:0] r_v0, r_v1;
    logic [WORD_SIZE-1:0] r_k0, r_k1, r_k2, r_k3;
    logic [WORD_SIZE-1:0] r_sum;
    logic [WORD_SIZE-1:0] r_c0, r_c1;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_decrypt;
    logic                 r_done;
    logic                 w_busy;

    logic                 w_sel_v1;
    logic [WORD_SIZE-1:0] w_x, w_target, w_ka, w_kb, w_fsum, w_f, w_upd;
    logic [WORD_SIZE-1:0] w_sum_next;
    logic [WORD_SIZE-1:0] w_sum_init;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b1;
        case (r_state)
            IDLE: begin
                w_busy = 1'b0;
                if (iStart) begin
                    w_state_next = HALF_A;
                end
            end
            HALF_A:  w_state_next = HALF_B;
            HALF_B:  w_state_next = (r_cnt == c_LAST) ? DONE : HALF_A;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Half-round operand steering. The half that reads v1 always updates
    // v0 with keys K0/K1; which half that is flips with the direction.
    // ------------------------------------------------------------------
    assign w_sel_v1   = (r_state == HALF_A) ^ r_decrypt;
    assign w_x        = w_sel_v1 ? r_v1 : r_v0;
    assign w_target   = w_sel_v1 ? r_v0 : r_v1;
    assign w_kb       = w_sel_v1 ? r_k1 : r_k3;
    assign w_sum_next = r_decrypt ? (r_sum - c_DELTA) : (r_sum + c_DELTA);
    assign w_upd      = r_decrypt ? (w_target - w_f) : (w_target + w_f);

`ifdef TEA_CORE_XTEA_EN
    logic                 r_xtea;
    logic [1:0]           w_kidx;
    logic [WORD_SIZE-1:0] w_xkey;

    // XTEA's second half sees the already-stepped sum.
    assign w_fsum = (r_xtea && (r_state == HALF_B)) ? w_sum_next : r_sum;
    assign w_kidx = w_sel_v1 ? w_fsum[1:0] : 2'(w_fsum >> 11);

    always_comb begin
        w_xkey = r_k0;
        case (w_kidx)
            2'd0:    w_xkey = r_k0;
            2'd1:    w_xkey = r_k1;
            2'd2:    w_xkey = r_k2;
            default: w_xkey = r_k3;
        endcase
    end

    assign w_ka       = r_xtea ? w_xkey : (w_sel_v1 ? r_k0 : r_k2);
    assign w_sum_init = iDecrypt ? c_DEC_SUM : (iXtea ? '0 : c_DELTA);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_xtea <= 1'b0;
        end else if ((r_state == IDLE) && iStart) begin
            r_xtea <= iXtea;
        end
    end
`else
    assign w_fsum     = r_sum;
    assign w_ka       = w_sel_v1 ? r_k0 : r_k2;
    assign w_sum_init = iDecrypt ? c_DEC_SUM : c_DELTA;
`endif

    tea_round_f #(
        .WORD_SIZE (WORD_SIZE)
    ) u_round_f (
        .i_x    (w_x),
        .i_ka   (w_ka),
        .i_kb   (w_kb),
        .i_sum  (w_fsum),
`ifdef TEA_CORE_XTEA_EN
        .i_xtea (r_xtea),
`endif
        .o_f    (w_f)
    );

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v0      <= '0;
            r_v1      <= '0;
            r_k0      <= '0;
            r_k1      <= '0;
            r_k2      <= '0;
            r_k3      <= '0;
            r_sum     <= '0;
            r_cnt     <= '0;
            r_decrypt <= 1'b0;
            r_c0      <= '0;
            r_c1      <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (iStart) begin
                        r_v0      <= iV0;
                        r_v1      <= iV1;
                        r_k0      <= iK0;
                        r_k1      <= iK1;
                        r_k2      <= iK2;
                        r_k3      <= iK3;
                        r_decrypt <= iDecrypt;
                        r_cnt     <= '0;
                        r_sum     <= w_sum_init;
                    end
                end
                HALF_A: begin
                    if (w_sel_v1) begin
                        r_v0 <= w_upd;
                    end else begin
                        r_v1 <= w_upd;
                    end
                end
                HALF_B: begin
                    if (w_sel_v1) begin
                        r_v0 <= w_upd;
                    end else begin
                        r_v1 <= w_upd;
                    end
                    r_sum <= w_sum_next;
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
                DONE: begin
                    r_c0   <= r_v0;
                    r_c1   <= r_v1;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign oC0   = r_c0;
    assign oC1   = r_c1;
    assign oBusy = w_busy;
    assign oDone = r_done;

endmodule

`default_nettype wire

// File: tb/tb_tea_core.sv
// ============================================================================
// Module   : tb_tea_core
// Brief    : Randomised scoreboard bench for tea_core against a C-style TEA
//            (and, with TEA_CORE_XTEA_EN, XTEA) reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_tea_core;

    localparam logic [31:0] c_DELTA  = 32'h9e3779b9;
    localparam int          c_ROUNDS = 32;
    localparam int          c_LAT    = 2 * c_ROUNDS + 1;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        iStart   = 1'b0;
    logic        iDecrypt = 1'b0;
    logic [31:0] iV0 = '0, iV1 = '0, iK0 = '0, iK1 = '0, iK2 = '0, iK3 = '0;
    logic [31:0] oC0, oC1;
    logic        oBusy, oDone;
`ifdef TEA_CORE_XTEA_EN
    logic        iXtea = 1'b0;
`endif

    tea_core dut (
        .clk      (clk),
        .rst      (rst),
        .iStart   (iStart),
        .iDecrypt (iDecrypt),
`ifdef TEA_CORE_XTEA_EN
        .iXtea    (iXtea),
`endif
        .iV0      (iV0),
        .iV1      (iV1),
        .iK0      (iK0),
        .iK1      (iK1),
        .iK2      (iK2),
        .iK3      (iK3),
        .oC0      (oC0),
        .oC1      (oC1),
        .oBusy    (oBusy),
        .oDone    (oDone)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] c0;
        logic [31:0] c1;
        int          start;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    bit   prev_done = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model (textbook C formulation) ----------------
    function automatic logic [31:0] kw(input logic [127:0] k, input logic [1:0] i);
        return k[32*i +: 32];
    endfunction

    function automatic logic [63:0] m_tea_enc(input logic [31:0] a, b, input logic [127:0] k);
        logic [31:0] v0, v1, s;
        v0 = a; v1 = b; s = 0;
        for (int i = 0; i < c_ROUNDS; i++) begin
            s  += c_DELTA;
            v0 += ((v1 << 4) + kw(k, 0)) ^ (v1 + s) ^ ((v1 >> 5) + kw(k, 1));
            v1 += ((v0 << 4) + kw(k, 2)) ^ (v0 + s) ^ ((v0 >> 5) + kw(k, 3));
        end
        return {v0, v1};
    endfunction

    function automatic logic [63:0] m_tea_dec(input logic [31:0] a, b, input logic [127:0] k);
        logic [31:0] v0, v1, s;
        v0 = a; v1 = b; s = c_DELTA * 32'(c_ROUNDS);
        for (int i = 0; i < c_ROUNDS; i++) begin
            v1 -= ((v0 << 4) + kw(k, 2)) ^ (v0 + s) ^ ((v0 >> 5) + kw(k, 3));
            v0 -= ((v1 << 4) + kw(k, 0)) ^ (v1 + s) ^ ((v1 >> 5) + kw(k, 1));
            s  -= c_DELTA;
        end
        return {v0, v1};
    endfunction

`ifdef TEA_CORE_XTEA_EN
    function automatic logic [63:0] m_xtea_enc(input logic [31:0] a, b, input logic [127:0] k);
        logic [31:0] v0, v1, s;
        v0 = a; v1 = b; s = 0;
        for (int i = 0; i < c_ROUNDS; i++) begin
            v0 += (((v1 << 4) ^ (v1 >> 5)) + v1) ^ (s + kw(k, s[1:0]));
            s  += c_DELTA;
            v1 += (((v0 << 4) ^ (v0 >> 5)) + v0) ^ (s + kw(k, s[12:11]));
        end
        return {v0, v1};
    endfunction

    function automatic logic [63:0] m_xtea_dec(input logic [31:0] a, b, input logic [127:0] k);
        logic [31:0] v0, v1, s;
        v0 = a; v1 = b; s = c_DELTA * 32'(c_ROUNDS);
        for (int i = 0; i < c_ROUNDS; i++) begin
            v1 -= (((v0 << 4) ^ (v0 >> 5)) + v0) ^ (s + kw(k, s[12:11]));
            s  -= c_DELTA;
            v0 -= (((v1 << 4) ^ (v1 >> 5)) + v1) ^ (s + kw(k, s[1:0]));
        end
        return {v0, v1};
    endfunction
`endif

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            prev_done = 1'b0;
        end else begin
            if (prev_done) chk("done_pulse_width", 32'(oDone), 32'd0);
            if (oDone && !prev_done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_done: got oDone with %h/%h expected none", oC0, oC1);
                end else begin
                    e = sb.pop_front();
                    chk("oC0", oC0, e.c0);
                    chk("oC1", oC1, e.c1);
                    chk("latency", 32'(cyc - e.start), 32'(c_LAT));
                end
            end
            prev_done = oDone;
        end
    end

    // ---------------- driver helpers ----------------
    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (oBusy && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (oBusy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got oBusy=1 after %0d cycles expected 0", budget);
        end
    endtask

    task automatic issue(input logic dec, input logic [31:0] v0, v1, input logic [127:0] k,
                         input logic [63:0] expv, input bit push);
        wait_idle(200);
        iDecrypt = dec;
        iV0 = v0; iV1 = v1;
        iK0 = kw(k, 0); iK1 = kw(k, 1); iK2 = kw(k, 2); iK3 = kw(k, 3);
        iStart = 1'b1;
        @(posedge clk);
        #1;
        if (push) sb.push_back('{expv[63:32], expv[31:0], cyc});
        iStart = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending results expected 0", sb.size());
            sb.delete();
        end
    endtask

    function automatic logic [31:0] r32();
        return $urandom;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0]  a, b;
        logic [127:0] k;
        logic [63:0]  ct, r;
        int           n;

        #2 rst = 1'b0;
        #1;
        chk("rst_oC0", oC0, 32'd0);
        chk("rst_oC1", oC1, 32'd0);
        chk("rst_busy", 32'(oBusy), 32'd0);
        chk("rst_done", 32'(oDone), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Known answers, all-zero key
        issue(1'b0, 32'h0, 32'h0, 128'h0, 64'h41ea3a0a_94baa940, 1'b1);
        chk("busy_after_start", 32'(oBusy), 32'd1);
        drain();
        issue(1'b1, 32'h41ea3a0a, 32'h94baa940, 128'h0, 64'h0, 1'b1);
        drain();
        @(negedge clk);
        chk("busy_idle", 32'(oBusy), 32'd0);

        // Random round trips and direct decrypts
        for (int i = 0; i < 120; i++) begin
            a = r32(); b = r32(); k = {r32(), r32(), r32(), r32()};
            ct = m_tea_enc(a, b, k);
            issue(1'b0, a, b, k, ct, 1'b1);
            issue(1'b1, ct[63:32], ct[31:0], k, {a, b}, 1'b1);
            if (i % 8 == 0) issue(1'b1, a, b, k, m_tea_dec(a, b, k), 1'b1);
        end
        drain();

        // Inputs and iStart churn while busy must not disturb the block
        a = r32(); b = r32(); k = {r32(), r32(), r32(), r32()};
        issue(1'b0, a, b, k, m_tea_enc(a, b, k), 1'b1);
        n = 0;
        @(negedge clk);
        while (oBusy && n < 200) begin
            iStart = 1'(r32()); iDecrypt = 1'(r32());
            iV0 = r32(); iV1 = r32(); iK0 = r32(); iK1 = r32(); iK2 = r32(); iK3 = r32();
            @(negedge clk);
            n++;
        end
        iStart = 1'b0;
        repeat (10) @(negedge clk);
        drain();

        // Reset at round 10 aborts without oDone
        a = r32(); b = r32(); k = {r32(), r32(), r32(), r32()};
        issue(1'b0, a, b, k, 64'h0, 1'b0);
        repeat (20) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_oC0", oC0, 32'd0);
        chk("abort_oC1", oC1, 32'd0);
        chk("abort_busy", 32'(oBusy), 32'd0);
        chk("abort_done", 32'(oDone), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (70) @(negedge clk);
        issue(1'b0, a, b, k, m_tea_enc(a, b, k), 1'b1);
        drain();

        // iStart held high: three blocks spaced 2*ROUNDS+2 cycles apart
        a = r32(); b = r32(); k = {r32(), r32(), r32(), r32()};
        r = m_tea_enc(a, b, k);
        wait_idle(200);
        iDecrypt = 1'b0;
        iV0 = a; iV1 = b;
        iK0 = kw(k, 0); iK1 = kw(k, 1); iK2 = kw(k, 2); iK3 = kw(k, 3);
        iStart = 1'b1;
        @(posedge clk);
        #1;
        for (int j = 0; j < 3; j++) sb.push_back('{r[63:32], r[31:0], cyc + j * (c_LAT + 1)});
        n = 0;
        while (sb.size() > 1 && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        iStart = 1'b0;
        drain();

`ifdef TEA_CORE_XTEA_EN
        iXtea = 1'b1;
        issue(1'b0, 32'h0, 32'h0, 128'h0, 64'hdee9d4d8_f7131ed9, 1'b1);
        issue(1'b1, 32'hdee9d4d8, 32'hf7131ed9, 128'h0, 64'h0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            a = r32(); b = r32(); k = {r32(), r32(), r32(), r32()};
            ct = m_xtea_enc(a, b, k);
            issue(1'b0, a, b, k, ct, 1'b1);
            issue(1'b1, ct[63:32], ct[31:0], k, {a, b}, 1'b1);
            issue(1'b1, a, b, k, m_xtea_dec(a, b, k), 1'b1);
        end
        drain();
        iXtea = 1'b0;
`endif

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
